// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_pkg                                                |
// | Description : Shared PS/2 definitions: frame length, FSM state       |
// |               encoding for the device transmitter, odd parity.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ps2_pkg;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // Transmitter FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_BIT  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // PS/2 parity bit: set so that data plus parity has an odd number of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_tx_fifo                                            |
// | Description : Synchronous FIFO for scan-code bytes. Registered read  |
// |               data always presents the current head; pointers carry  |
// |               one extra wrap bit to tell full from empty.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ps2_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wptr;
  logic [c_AW:0]    r_rptr;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_wr;
  logic             w_rd;

  // Same index with different wrap bits means the writer lapped the reader
  assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_level = r_wptr - r_rptr;
  assign o_data  = r_rd_data;

  // Storage array; contents need no reset since the pointers gate validity
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[c_AW-1:0]] <= i_data;
    end
  end

  // Read/write pointers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Registered head: a byte written on one edge is visible here after the next
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[r_rptr[c_AW-1:0]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_keyboard_tx                                        |
// | Description : Device-side PS/2 keyboard transmitter. Buffers bytes   |
// |               in a FIFO and serialises each as an 11-bit frame on    |
// |               ps2_clk/ps2_data, honouring host inhibit.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF = 50,
  parameter int GAP      = 200,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     host_inhibit,
  output logic                     ps2_clk,
  output logic                     ps2_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int                    c_CNT_W    = $clog2(2 * CLK_HALF);
  localparam int                    c_GAP_W    = $clog2(GAP + 1);
  localparam logic [c_CNT_W-1:0]    c_HALF     = c_CNT_W'(CLK_HALF);
  localparam logic [c_CNT_W-1:0]    c_BIT_LAST = c_CNT_W'(2 * CLK_HALF - 1);
  localparam logic [c_GAP_W-1:0]    c_GAP_LAST = c_GAP_W'(GAP - 1);
  localparam logic [3:0]            c_LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [1:0]                r_state;
  logic [c_CNT_W-1:0]        r_cnt;
  logic [3:0]                r_bit;
  logic [PS2_FRAME_BITS-1:0] r_frame;
  logic [c_GAP_W-1:0]        r_gap_cnt;
  logic                      r_ps2_clk;
  logic                      r_frame_done;

  logic                      w_full;
  logic                      w_empty;
  logic [7:0]                w_head;
  logic                      w_pop;
  logic                      w_late;
  logic                      w_abort;
  logic                      w_bit_end;
  logic [c_CNT_W-1:0]        w_cnt_nxt;

  ps2_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign in_ready   = !w_full;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_frame_done;
  assign ps2_clk    = r_ps2_clk;
  // Bit 0 of the shift register is the bit on the wire, so data is a flop output
  assign ps2_data   = r_frame[0];

  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_bit_end  = (r_cnt == c_BIT_LAST);
  // Once the stop bit's falling edge is out, the host has sampled the whole frame
  assign w_late     = (r_bit == c_LAST_BIT) && (r_cnt >= c_HALF);
  assign w_abort    = (r_state == ST_BIT) && host_inhibit && !w_late;
  assign w_pop      = (r_state == ST_BIT) && w_bit_end && (r_bit == c_LAST_BIT);

  // Transmit FSM with bit timing, shift register and bus drivers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_frame      <= '1;
      r_gap_cnt    <= '0;
      r_ps2_clk    <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && !host_inhibit) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Head is copied but stays in the FIFO so an aborted frame can be resent
          r_frame   <= {1'b1, odd_parity(w_head), w_head, 1'b0};
          r_bit     <= '0;
          r_cnt     <= '0;
          r_ps2_clk <= 1'b1;
          r_state   <= ST_BIT;
        end
        ST_BIT: begin
          if (w_abort) begin
            r_ps2_clk <= 1'b1;
            r_frame   <= '1;
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end else if (w_bit_end) begin
            if (r_bit == c_LAST_BIT) begin
              r_frame_done <= 1'b1;
              r_ps2_clk    <= 1'b1;
              r_frame      <= '1;
              r_gap_cnt    <= '0;
              r_state      <= ST_GAP;
            end else begin
              // New data is launched together with the rising clock
              r_bit     <= r_bit + 4'd1;
              r_cnt     <= '0;
              r_frame   <= {1'b1, r_frame[PS2_FRAME_BITS-1:1]};
              r_ps2_clk <= 1'b1;
            end
          end else begin
            r_cnt     <= w_cnt_nxt;
            r_ps2_clk <= (w_cnt_nxt < c_HALF);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ps2_keyboard_tx                                     |
// | Description : Directed bench for ps2_keyboard_tx with a host-side    |
// |               frame capture model on the ps2_clk falling edges.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ps2_keyboard_tx;

  localparam int CH = 4;
  localparam int GP = 20;
  localparam int DP = 4;

  logic                 clk;
  logic                 resetn;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 host_inhibit;
  logic                 ps2_clk;
  logic                 ps2_data;
  logic                 busy;
  logic                 frame_done;
  logic [$clog2(DP):0]  fifo_level;

  ps2_keyboard_tx #(
    .CLK_HALF (CH),
    .GAP      (GP),
    .DEPTH    (DP)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .host_inhibit (host_inhibit),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .busy         (busy),
    .frame_done   (frame_done),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte and its expected wire frame, bit i = i-th bit sent (start at bit 0)
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t tbl[7];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Host-side receiver model
  logic        prev_clk = 1'b1;
  logic [10:0] sh       = '0;
  int          nbits    = 0;
  int          hi_cnt   = 0;
  int          falls    = 0;
  int          done_cnt = 0;
  int          partials = 0;
  logic [10:0] rx_q[$];
  int          first_fall_q[$];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (prev_clk && !ps2_clk) begin
      falls = falls + 1;
      if (nbits == 0) first_fall_q.push_back(cyc);
      sh     = {ps2_data, sh[10:1]};
      nbits  = nbits + 1;
      hi_cnt = 0;
      if (nbits == 11) begin
        rx_q.push_back(sh);
        nbits = 0;
      end
    end else if (ps2_clk) begin
      hi_cnt = hi_cnt + 1;
      if (hi_cnt > 4 * CH && nbits != 0) begin
        nbits    = 0;
        partials = partials + 1;
      end
    end else begin
      hi_cnt = 0;
    end
    if (frame_done) done_cnt = done_cnt + 1;
    prev_clk = ps2_clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    cmp("push_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    cmp("wait_frames", {31'd0, rx_q.size() >= n}, 32'd1);
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (done_cnt < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    cmp("wait_done", {31'd0, done_cnt >= n}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int k;
  int base;
  int snap;
  int t;
  bit saw_full;

  initial begin
    tbl[0] = '{8'h1C, 11'h438};
    tbl[1] = '{8'hF0, 11'h7E0};
    tbl[2] = '{8'h00, 11'h600};
    tbl[3] = '{8'hFF, 11'h7FE};
    tbl[4] = '{8'h01, 11'h402};
    tbl[5] = '{8'h80, 11'h500};
    tbl[6] = '{8'h5A, 11'h6B4};

    resetn       = 1'b0;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    host_inhibit = 1'b0;
    idle_cycles(3);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state
    cmp("rst_ps2_clk",    {31'd0, ps2_clk},    32'd1);
    cmp("rst_ps2_data",   {31'd0, ps2_data},   32'd1);
    cmp("rst_in_ready",   {31'd0, in_ready},   32'd1);
    cmp("rst_busy",       {31'd0, busy},       32'd0);
    cmp("rst_frame_done", {31'd0, frame_done}, 32'd0);
    cmp("rst_level",      {29'd0, fifo_level}, 32'd0);

    // Start latency and frame length for 0x1C
    in_valid = 1'b1;
    in_data  = 8'h1C;
    @(negedge clk);
    in_valid = 1'b0;
    cmp("lat_level",     {29'd0, fifo_level}, 32'd1);
    cmp("lat_idle_busy", {31'd0, busy},       32'd0);
    @(negedge clk);
    cmp("lat_load_busy", {31'd0, busy},       32'd1);
    cmp("lat_load_data", {31'd0, ps2_data},   32'd1);
    @(negedge clk);
    cmp("lat_start_data", {31'd0, ps2_data},  32'd0);
    cmp("lat_start_clk",  {31'd0, ps2_clk},   32'd1);
    k = 0;
    while (!frame_done && k < 300) begin
      @(negedge clk);
      k++;
    end
    cmp("done_latency", k, 32'd88);
    @(negedge clk);
    cmp("done_pulse_width", {31'd0, frame_done}, 32'd0);
    wait_frames(1);
    cmp("frame_1C", {21'd0, rx_q[0]}, 32'h438);
    cmp("done_count_1", done_cnt, 32'd1);

    // Table of single bytes, each sent and drained before the next
    rx_q.delete();
    for (int i = 0; i < 7; i++) begin
      base = done_cnt;
      push_byte(tbl[i].data);
      wait_frames(i + 1);
      wait_done(base + 1);
      cmp($sformatf("tbl_frame_%0d", i), {21'd0, rx_q[i]}, {21'd0, tbl[i].frame});
      cmp($sformatf("tbl_done_%0d", i), done_cnt - base, 32'd1);
      @(negedge clk);
      cmp($sformatf("tbl_level_%0d", i), {29'd0, fifo_level}, 32'd0);
    end
    idle_cycles(GP + 4);

    // Back-to-back: F0 then 1C, spacing between starts
    rx_q.delete();
    first_fall_q.delete();
    push_byte(8'hF0);
    push_byte(8'h1C);
    wait_frames(2);
    cmp("b2b_frame0",  {21'd0, rx_q[0]},    32'h7E0);
    cmp("b2b_parity0", {31'd0, rx_q[0][9]}, 32'd1);
    cmp("b2b_frame1",  {21'd0, rx_q[1]},    32'h438);
    cmp("b2b_spacing", first_fall_q[1] - first_fall_q[0], 32'(22 * CH + GP + 2));
    idle_cycles(3 * CH + GP + 4);

    // Hold in_valid high for DEPTH+2 bytes
    rx_q.delete();
    base     = done_cnt;
    saw_full = 1'b0;
    for (int i = 0; i < DP + 2; i++) begin
      @(negedge clk);
      in_data  = tbl[i].data;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 3000) begin
        if (!saw_full) begin
          saw_full = 1'b1;
          cmp("full_level", {29'd0, fifo_level}, 32'(DP));
        end
        @(negedge clk);
        t++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    cmp("full_seen", {31'd0, saw_full}, 32'd1);
    wait_frames(DP + 2);
    wait_done(base + DP + 2);
    cmp("stream_count", rx_q.size(), 32'(DP + 2));
    for (int i = 0; i < DP + 2; i++) begin
      cmp($sformatf("stream_frame_%0d", i), {21'd0, rx_q[i]}, {21'd0, tbl[i].frame});
    end
    @(negedge clk);
    cmp("stream_drained", {29'd0, fifo_level}, 32'd0);
    idle_cycles(GP + 4);

    // Inhibit during bit 5 of 0x1C
    rx_q.delete();
    base = done_cnt;
    snap = falls;
    push_byte(8'h1C);
    t = 0;
    while (falls < snap + 6 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    host_inhibit = 1'b1;
    @(negedge clk);
    cmp("abort_clk_high",  {31'd0, ps2_clk},  32'd1);
    cmp("abort_data_high", {31'd0, ps2_data}, 32'd1);
    snap = falls;
    idle_cycles(100);
    cmp("abort_no_edges", falls - snap, 32'd0);
    cmp("abort_no_done",  done_cnt - base, 32'd0);
    cmp("abort_level",    {29'd0, fifo_level}, 32'd1);
    cmp("abort_idle",     {31'd0, busy}, 32'd0);
    cmp("abort_partial",  partials, 32'd1);
    host_inhibit = 1'b0;
    wait_frames(1);
    wait_done(base + 1);
    cmp("abort_resent", {21'd0, rx_q[0]}, 32'h438);
    cmp("abort_done_once", done_cnt - base, 32'd1);
    idle_cycles(GP + 4);

    // Inhibit while idle with a byte queued
    rx_q.delete();
    host_inhibit = 1'b1;
    snap = falls;
    push_byte(8'h5A);
    idle_cycles(150);
    cmp("inh_idle_edges", falls - snap, 32'd0);
    cmp("inh_idle_data",  {31'd0, ps2_data}, 32'd1);
    cmp("inh_idle_busy",  {31'd0, busy}, 32'd0);
    cmp("inh_idle_level", {29'd0, fifo_level}, 32'd1);
    host_inhibit = 1'b0;
    wait_frames(1);
    cmp("inh_idle_frame", {21'd0, rx_q[0]}, 32'h6B4);
    idle_cycles(3 * CH + GP + 4);

    // Reset in the middle of a frame
    rx_q.delete();
    base = done_cnt;
    snap = falls;
    push_byte(8'hFF);
    t = 0;
    while (falls < snap + 3 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    cmp("mrst_clk",   {31'd0, ps2_clk},    32'd1);
    cmp("mrst_data",  {31'd0, ps2_data},   32'd1);
    cmp("mrst_level", {29'd0, fifo_level}, 32'd0);
    cmp("mrst_busy",  {31'd0, busy},       32'd0);
    cmp("mrst_ready", {31'd0, in_ready},   32'd1);
    idle_cycles(80);
    cmp("mrst_no_frame", rx_q.size(), 32'd0);
    cmp("mrst_no_done",  done_cnt - base, 32'd0);
    cmp("mrst_partial",  partials, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard_tx.md
# ps2_keyboard_tx

Device-side PS/2 keyboard transmitter. It accepts scan-code bytes over a valid/ready interface, buffers them in a small FIFO, and serialises each byte onto `ps2_clk`/`ps2_data` as a standard 11-bit PS/2 frame. It sits opposite the host-side PS/2 receiver. It drives that receiver in simulation and NVBoard loopback, so scan codes and break sequences can be injected without a physical keyboard.

## Interface
- `CLK_HALF`, default 50: system clocks per `ps2_clk` half-period. Must be ≥ 4.
- `GAP`, default 200: idle system clocks after every frame, with clk and data both high.
- `DEPTH`, default 8: FIFO entries. Must be a power of 2, ≥ 2.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  scan-code byte offered.
- `in_data`  in  8  scan-code byte.
- `in_ready`  out  1  FIFO can accept a byte; equals `!full`.
- `host_inhibit`  in  1  host is holding the bus; when high, no frame may start and an in-progress frame aborts.
- `ps2_clk`  out  1  PS/2 clock; idle high.
- `ps2_data`  out  1  PS/2 data; idle high.
- `busy`  out  1  FSM is not in IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame completes its stop bit.
- `fifo_level`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- **Frame format**, 11 bits in this order:
  - start = 0;
  - `d[0]`..`d[7]`, LSB first;
  - parity = `~^d` (odd parity);
  - stop = 1.
- **Push:** occurs when `in_valid && in_ready`. A pop in the same cycle does not raise `in_ready` while the FIFO is full. Push and pop in the same cycle leaves `fifo_level` unchanged.
- **FSM states:**
  - IDLE → LOAD when FIFO is non-empty and `!host_inhibit`.
  - LOAD: latch the FIFO head into the shift register and compute parity, without popping. Then go to BIT with bit index 0.
  - BIT: advance through bit index 0..10. After bit 10 completes, pop the FIFO head, pulse `frame_done`, and go to GAP.
  - GAP: count `GAP` cycles, then go to IDLE.
- **Abort:** if `host_inhibit` rises in BIT before the falling edge of bit 10:
  - `ps2_clk` and `ps2_data` are forced high on the next cycle;
  - no pop and no `frame_done`;
  - go to GAP.
  - The same byte is resent in full once inhibit drops.
- **Inhibit after the bit-10 falling edge:** the frame counts as complete.
- **Inhibit in GAP:** no effect; IDLE then holds until inhibit drops.
- **Reset, including mid-frame:** FIFO empty, FSM in IDLE, `ps2_clk`=1, `ps2_data`=1, `in_ready`=1, `busy`=0, `frame_done`=0, `fifo_level`=0. The partial frame is discarded.

## Timing
- **Bit period:** 2·`CLK_HALF` cycles. `ps2_data` changes only at the start of the period, while `ps2_clk` is high.
- **Clock shape within a bit:** `ps2_clk` is high for the first `CLK_HALF` cycles and low for the second `CLK_HALF` cycles.
- **Sampling margin:** the falling edge falls `CLK_HALF` cycles after data changes. The receiver samples on that edge, so data is held `CLK_HALF` cycles before it and `CLK_HALF` cycles after it.
- **Frame length:** 22·`CLK_HALF` cycles. The frame ends with `ps2_clk` high.
- **Start latency:** a byte pushed into an empty FIFO while the FSM is idle produces the start bit on `ps2_data` 2 cycles after the push edge (FIFO write, then LOAD).
- **`frame_done`:** asserted in the cycle after the last low cycle of bit 10.
- **Back-to-back frames:** start-bit spacing is 22·`CLK_HALF` + `GAP` + 2 cycles.
- **Registered outputs:** `ps2_clk` and `ps2_data` come straight from flops, with no combinational path from inputs.

## Structure
- **Shared package `ps2_pkg`:**
  - FSM state encoding (IDLE, LOAD, BIT, GAP);
  - `PS2_FRAME_BITS` = 11;
  - odd-parity function.
  - The host receiver reuses the frame constant and the parity function.
- **Sub-module `ps2_tx_fifo`:** synchronous FIFO with registered read data and `DEPTH`-parameterised pointers. It has one extra pointer bit to distinguish full from empty, and its level output feeds `fifo_level`.
- **Top-level logic:** FSM, half-period counter, 4-bit bit index, 11-bit frame shift register.

## Test plan
- Push 0x1C with `CLK_HALF`=4:
  - `ps2_data` at the 11 falling edges reads 0,0,0,1,1,1,0,0,0,0,1 (parity 0);
  - `frame_done` pulses once, 88 cycles after the start bit;
  - the host receiver reports 0x1C.
- Push 0xF0, 0x1C back to back:
  - 0xF0 parity bit = 1;
  - start-bit spacing = 88+`GAP`+2 cycles;
  - both codes are received in order.
- Push `DEPTH`+2 bytes with `in_valid` held high:
  - `in_ready` drops at level `DEPTH`;
  - no byte is lost or duplicated;
  - `fifo_level` drains to 0.
- Assert `host_inhibit` during bit 5 of 0x1C:
  - bus returns to 1/1 the next cycle;
  - no `frame_done` and `fifo_level` is unchanged;
  - after release, a full 0x1C frame is resent and received.
- Assert `host_inhibit` while idle with a non-empty FIFO: no bus activity until release, then normal transmission.
- Deassert `resetn` mid-frame:
  - next cycle `ps2_clk`=`ps2_data`=1, `fifo_level`=0, `busy`=0;
  - the receiver reports no frame.
